hdlc_tx_channel: RTL and testbench

- Serial transmit channel of the HDLC controller; the transmit-direction counterpart of the Rx flag/zero-removal path.
- Pulls frame bytes (payload plus FCS, already in buffer order) from the Tx buffer, one byte per request.
- Emits start flag, zero-stuffed data LSB-first, and end flag on Tx.
- Supports mid-frame abort and reports Tx_Done to the register interface.

---
 rtl/hdlc_pkg.sv | 29 ++
 rtl/hdlc_zero_insert.sv | 47 ++++
 rtl/hdlc_tx_channel.sv | 213 +++++++++++++++++++++
 tb/tb_hdlc_tx_channel.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_pkg.sv
// rtl/hdlc_pkg.sv - shared HDLC framing types and constants for the Tx and Rx channels
package hdlc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_FLAG,
    DATA,
    END_FLAG,
    ABORT
  } tx_state_t;

  localparam logic [7:0]  HDLC_FLAG   = 8'h7E;
  localparam logic [7:0]  HDLC_ABORT  = 8'hFE;
  localparam int unsigned STUFF_LIMIT = 5;

  // Zero-length requests become one byte; oversize requests saturate at the limit.
  function automatic logic [6:0] clamp_frame_size(input logic [6:0] size,
                                                  input logic [6:0] max_size);
    logic [6:0] r;
    r = size;
    if (size == 7'd0) begin
      r = 7'd1;
    end else if (size > max_size) begin
      r = max_size;
    end
    return r;
  endfunction

endpackage

// File: rtl/hdlc_zero_insert.sv
// rtl/hdlc_zero_insert.sv - consecutive-ones tracker that forces a stuffed zero after five ones
module hdlc_zero_insert
  import hdlc_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic advance_i,
  input  logic bit_i,
  output logic bit_o,
  output logic stall_o,
  output logic stall_next_o
);

  localparam logic [2:0] LIMIT = 3'(STUFF_LIMIT);

  logic [2:0] ones_q, ones_d;

  // A full run means the current bit period carries the stuffed zero instead of data.
  assign stall_o      = (ones_q == LIMIT);
  assign bit_o        = stall_o ? 1'b0 : bit_i;
  assign stall_next_o = !stall_o && bit_i && (ones_q == (LIMIT - 3'd1));

  // Count data ones; zeros, stuffed bits and leaving the data field restart the run.
  always_comb begin
    ones_d = ones_q;
    if (clear_i) begin
      ones_d = 3'd0;
    end else if (advance_i) begin
      if (stall_o || !bit_i) begin
        ones_d = 3'd0;
      end else begin
        ones_d = ones_q + 3'd1;
      end
    end
  end

  // Ones counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ones_q <= 3'd0;
    end else begin
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/hdlc_tx_channel.sv
// rtl/hdlc_tx_channel.sv - HDLC serial transmit channel with flags, zero stuffing and abort
module hdlc_tx_channel
  import hdlc_pkg::*;
#(
  parameter int unsigned MAX_FRAME = 126
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tx_en_i,
  input  logic       valid_frame_i,
  input  logic       abort_frame_i,
  input  logic [6:0] frame_size_i,
  input  logic [7:0] data_i,
  output logic       rd_buff_o,
  output logic       tx_o,
  output logic       tx_done_o,
  output logic       aborted_trans_o
);

  localparam logic [6:0] MAX_SIZE = 7'(MAX_FRAME);

  tx_state_t  state_q, state_d;
  logic       tx_q, tx_d;
  logic       rd_buff_q, rd_buff_d;
  logic       tx_done_q, tx_done_d;
  logic       aborted_q, aborted_d;
  logic       abort_pend_q, abort_pend_d;
  logic       last_stuff_q, last_stuff_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] size_q, size_d;
  logic [6:0] loaded_q, loaded_d;

  logic zi_bit, zi_stall, zi_stall_next, zi_advance, zi_clear;
  logic bit_last, bytes_left, active;

  assign bit_last   = (bit_cnt_q == 3'd7);
  assign bytes_left = (loaded_q < size_q);
  assign active     = (state_q == START_FLAG) || (state_q == DATA) || (state_q == END_FLAG);

  // The ones counter only runs while data bits go out and a pending abort is not pre-empting them.
  assign zi_advance = tx_en_i && (state_q == DATA) && !abort_pend_q;
  assign zi_clear   = (state_q != DATA);

  hdlc_zero_insert u_zero_insert (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (zi_clear),
    .advance_i   (zi_advance),
    .bit_i       (shift_q[0]),
    .bit_o       (zi_bit),
    .stall_o     (zi_stall),
    .stall_next_o(zi_stall_next)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision, taken only on bit-enabled edges.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (tx_en_i && valid_frame_i) state_d = START_FLAG;
      end
      START_FLAG: begin
        if (tx_en_i) begin
          if (abort_pend_q)  state_d = ABORT;
          else if (bit_last) state_d = DATA;
        end
      end
      DATA: begin
        if (tx_en_i) begin
          if (abort_pend_q) begin
            state_d = ABORT;
          end else if (zi_stall) begin
            if (last_stuff_q) state_d = END_FLAG;
          end else if (bit_last && !bytes_left && !zi_stall_next) begin
            state_d = END_FLAG;
          end
        end
      end
      END_FLAG: begin
        if (tx_en_i) begin
          if (abort_pend_q)  state_d = ABORT;
          else if (bit_last) state_d = IDLE;
        end
      end
      ABORT: begin
        if (tx_en_i && bit_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Serial line, buffer requests and byte bookkeeping for the bit being emitted on this edge.
  always_comb begin
    tx_d         = tx_q;
    rd_buff_d    = 1'b0;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    size_d       = size_q;
    loaded_d     = loaded_q;
    last_stuff_d = last_stuff_q;
    hold_d       = rd_buff_q ? data_i : hold_q;
    tx_done_d    = (state_d == IDLE);
    aborted_d    = (state_q == ABORT) && (state_d == IDLE);

    // Abort requests only matter inside a frame; the pending bit drops once ABORT is entered.
    abort_pend_d = abort_pend_q;
    if (!active)            abort_pend_d = 1'b0;
    else if (abort_frame_i) abort_pend_d = 1'b1;

    if (tx_en_i) begin
      if (active && abort_pend_q) begin
        tx_d         = HDLC_ABORT[0];
        bit_cnt_d    = 3'd1;
        abort_pend_d = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            tx_d = 1'b1;
            if (valid_frame_i) begin
              size_d       = clamp_frame_size(frame_size_i, MAX_SIZE);
              rd_buff_d    = 1'b1;
              bit_cnt_d    = 3'd0;
              loaded_d     = 7'd0;
              last_stuff_d = 1'b0;
            end
          end
          START_FLAG: begin
            tx_d = HDLC_FLAG[bit_cnt_q];
            if (bit_last) begin
              shift_d   = hold_q;
              loaded_d  = loaded_q + 7'd1;
              rd_buff_d = ((loaded_q + 7'd1) < size_q);
              bit_cnt_d = 3'd0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
          DATA: begin
            tx_d = zi_bit;
            if (!zi_stall) begin
              shift_d   = {1'b0, shift_q[7:1]};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_last) begin
                if (bytes_left) begin
                  shift_d   = hold_q;
                  loaded_d  = loaded_q + 7'd1;
                  rd_buff_d = ((loaded_q + 7'd1) < size_q);
                end else if (zi_stall_next) begin
                  last_stuff_d = 1'b1;
                end
              end
            end
          end
          END_FLAG: begin
            tx_d      = HDLC_FLAG[bit_cnt_q];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          ABORT: begin
            tx_d      = HDLC_ABORT[bit_cnt_q];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          default: tx_d = 1'b1;
        endcase
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_q         <= 1'b1;
      rd_buff_q    <= 1'b0;
      tx_done_q    <= 1'b1;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      last_stuff_q <= 1'b0;
      hold_q       <= 8'd0;
      shift_q      <= 8'd0;
      bit_cnt_q    <= 3'd0;
      size_q       <= 7'd0;
      loaded_q     <= 7'd0;
    end else begin
      tx_q         <= tx_d;
      rd_buff_q    <= rd_buff_d;
      tx_done_q    <= tx_done_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
      last_stuff_q <= last_stuff_d;
      hold_q       <= hold_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      size_q       <= size_d;
      loaded_q     <= loaded_d;
    end
  end

  assign tx_o            = tx_q;
  assign rd_buff_o       = rd_buff_q;
  assign tx_done_o       = tx_done_q;
  assign aborted_trans_o = aborted_q;

endmodule

// File: tb/tb_hdlc_tx_channel.sv
// tb/tb_hdlc_tx_channel.sv - scoreboard bench for the HDLC transmit channel
module tb_hdlc_tx_channel;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_en;
  logic       valid_frame;
  logic       abort_frame;
  logic [6:0] frame_size;
  logic [7:0] data;
  logic       rd_buff;
  logic       tx;
  logic       tx_done;
  logic       aborted;

  int checks = 0;
  int errors = 0;

  logic [7:0] fb[$];
  bit         exp_q[$];

  always #5 clk = ~clk;

  hdlc_tx_channel #(.MAX_FRAME(126)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .tx_en_i        (tx_en),
    .valid_frame_i  (valid_frame),
    .abort_frame_i  (abort_frame),
    .frame_size_i   (frame_size),
    .data_i         (data),
    .rd_buff_o      (rd_buff),
    .tx_o           (tx),
    .tx_done_o      (tx_done),
    .aborted_trans_o(aborted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line image of a frame: flag, data with a zero after every fifth one, flag.
  // An abort keeps the first abort_at+1 bits and then appends the abort pattern.
  task automatic build_expected(input int abort_at);
    bit         all[$];
    logic [7:0] flag = 8'h7E;
    logic [7:0] ab   = 8'hFE;
    logic [7:0] byt;
    int         ones = 0;
    for (int i = 0; i < 8; i++) all.push_back(flag[i]);
    foreach (fb[j]) begin
      byt = fb[j];
      for (int i = 0; i < 8; i++) begin
        all.push_back(byt[i]);
        if (byt[i]) ones++;
        else ones = 0;
        if (ones == 5) begin
          all.push_back(1'b0);
          ones = 0;
        end
      end
    end
    for (int i = 0; i < 8; i++) all.push_back(flag[i]);
    if (abort_at >= 0) begin
      while (all.size() > abort_at + 1) void'(all.pop_back());
      for (int i = 0; i < 8; i++) all.push_back(ab[i]);
    end
    foreach (all[k]) exp_q.push_back(all[k]);
  endtask

  task automatic run_frame(input string name, input logic [6:0] size_in, input int en_div,
                           input int abort_at, input int exp_rd);
    int         idx = 0, rd_cnt = 0, ab_cnt = 0, low = 0, seen = 0, flags = 0, cyc = 0;
    int         total, rd_tail = 0, ab_tail = 0;
    bit         abort_sent = 0;
    bit         e;
    logic       en_now, prev_tx;
    logic [7:0] rx_sr = 8'hFF;

    build_expected(abort_at);
    total = exp_q.size();
    frame_size  = size_in;
    valid_frame = 1'b1;
    tx_en       = 1'b1;
    step();
    valid_frame = 1'b0;
    if (rd_buff) begin
      rd_cnt++;
      if (idx < fb.size()) data = fb[idx];
      idx++;
    end
    if (!tx_done) low++;
    prev_tx = tx;

    while (!(exp_q.size() == 0 && tx_done) && cyc < 4000) begin
      en_now = ((cyc % en_div) == (en_div - 1));
      tx_en  = en_now;
      abort_frame = (abort_at >= 0) && (seen == abort_at) && !abort_sent;
      if (abort_frame) abort_sent = 1;
      step();
      cyc++;
      if (rd_buff) begin
        rd_cnt++;
        if (idx < fb.size()) data = fb[idx];
        idx++;
      end
      if (aborted) ab_cnt++;
      if (!tx_done) low++;
      if (en_now) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra bit: got %b after %0d bits, required none", name, tx, seen);
        end else begin
          e = exp_q.pop_front();
          if (tx !== e) begin
            errors++;
            $display("FAIL %s tx bit %0d: got %b required %b", name, seen, tx, e);
          end
          seen++;
          rx_sr = {tx, rx_sr[7:1]};
          if (rx_sr == 8'h7E) flags++;
        end
      end else begin
        checks++;
        if (tx !== prev_tx) begin
          errors++;
          $display("FAIL %s tx stable with TxEN=0: got %b required %b", name, tx, prev_tx);
        end
      end
      prev_tx = tx;
    end
    abort_frame = 1'b0;

    checks++;
    if (cyc >= 4000) begin
      errors++;
      $display("FAIL %s timeout: %0d bits left, tx_done %b", name, exp_q.size(), tx_done);
      exp_q.delete();
    end
    checks++;
    if (rd_cnt !== exp_rd) begin
      errors++;
      $display("FAIL %s rd_buff pulses: got %0d required %0d", name, rd_cnt, exp_rd);
    end
    checks++;
    if (ab_cnt !== ((abort_at >= 0) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s aborted_trans pulses: got %0d required %0d", name, ab_cnt,
               (abort_at >= 0) ? 1 : 0);
    end
    checks++;
    if (flags !== ((abort_at >= 0) ? 1 : 2)) begin
      errors++;
      $display("FAIL %s flag patterns seen: got %0d required %0d", name, flags,
               (abort_at >= 0) ? 1 : 2);
    end
    if (en_div == 1) begin
      checks++;
      if (low !== total) begin
        errors++;
        $display("FAIL %s tx_done low cycles: got %0d required %0d", name, low, total);
      end
    end

    tx_en = 1'b1;
    repeat (4) begin
      step();
      if (rd_buff) rd_tail++;
      if (aborted) ab_tail++;
    end
    checks++;
    if (rd_tail !== 0 || ab_tail !== 0 || tx !== 1'b1 || tx_done !== 1'b1) begin
      errors++;
      $display("FAIL %s idle after frame: rd %0d ab %0d tx %b done %b required 0 0 1 1",
               name, rd_tail, ab_tail, tx, tx_done);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset tx: got %b required 1", tx); end
    checks++;
    if (tx_done !== 1'b1) begin errors++; $display("FAIL reset tx_done: got %b required 1", tx_done); end
    checks++;
    if (rd_buff !== 1'b0) begin errors++; $display("FAIL reset rd_buff: got %b required 0", rd_buff); end
    checks++;
    if (aborted !== 1'b0) begin errors++; $display("FAIL reset aborted: got %b required 0", aborted); end
    rst_n = 1'b1;
    tx_en = 1'b1;
    step();
    abort_frame = 1'b1;
    step();
    abort_frame = 1'b0;
    repeat (10) begin
      step();
      if (aborted !== 1'b0 || tx_done !== 1'b1 || tx !== 1'b1 || rd_buff !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle abort ignored: got %0d bad cycles required 0", bad);
    end
  endtask

  task automatic test_single_zero();
    fb.delete();
    fb.push_back(8'h00);
    run_frame("single_00", 7'd1, 1, -1, 1);
  endtask

  task automatic test_ones_stuffing();
    fb.delete();
    fb.push_back(8'hFF);
    fb.push_back(8'hFF);
    run_frame("ones_ff", 7'd2, 1, -1, 2);
  endtask

  task automatic test_flag_payload();
    fb.delete();
    repeat (3) fb.push_back(8'h7E);
    run_frame("flag_payload", 7'd3, 1, -1, 3);
  endtask

  task automatic test_abort();
    fb.delete();
    fb.push_back(8'h12);
    fb.push_back(8'h34);
    fb.push_back(8'h56);
    fb.push_back(8'h78);
    run_frame("abort_mid", 7'd4, 1, 19, 3);
  endtask

  task automatic test_txen_gated();
    fb.delete();
    fb.push_back(8'hA5);
    run_frame("txen_1of3", 7'd1, 3, -1, 1);
  endtask

  task automatic test_reset_mid_frame();
    int idx = 0;
    fb.delete();
    fb.push_back(8'hC3);
    fb.push_back(8'h3C);
    fb.push_back(8'hC3);
    fb.push_back(8'h3C);
    frame_size  = 7'd4;
    tx_en       = 1'b1;
    valid_frame = 1'b1;
    step();
    valid_frame = 1'b0;
    repeat (14) begin
      if (rd_buff) begin
        data = fb[idx];
        idx++;
      end
      step();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_done !== 1'b1 || rd_buff !== 1'b0 || aborted !== 1'b0) begin
      errors++;
      $display("FAIL reset mid frame: tx %b done %b rd %b ab %b required 1 1 0 0",
               tx, tx_done, rd_buff, aborted);
    end
    step();
    rst_n = 1'b1;
    step();
    fb.delete();
    fb.push_back(8'hA5);
    run_frame("after_reset", 7'd1, 1, -1, 1);
  endtask

  task automatic test_size_bounds();
    fb.delete();
    fb.push_back(8'h5A);
    run_frame("size_zero", 7'd0, 1, -1, 1);
    fb.delete();
    repeat (126) fb.push_back(8'($urandom));
    run_frame("size_clamp", 7'd127, 1, -1, 126);
  endtask

  task automatic test_back_to_back();
    fb.delete();
    fb.push_back(8'hF8);
    fb.push_back(8'h1F);
    run_frame("b2b_first", 7'd2, 1, -1, 2);
    fb.delete();
    fb.push_back(8'hBE);
    run_frame("b2b_second", 7'd1, 1, -1, 1);
  endtask

  initial begin
    rst_n       = 1'b0;
    tx_en       = 1'b0;
    valid_frame = 1'b0;
    abort_frame = 1'b0;
    frame_size  = 7'd0;
    data        = 8'd0;
    test_reset();
    test_single_zero();
    test_ones_stuffing();
    test_flag_payload();
    test_abort();
    test_txen_gated();
    test_reset_mid_frame();
    test_size_bounds();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
